// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction
// fetch port (IF) and the data port (MEM). Alternating grant on ties, bus
// signals frozen until bus_ack, registered read data with a one-cycle ready
// pulse, and combinational stall outputs for the pipeline.
// Optional watchdog abort: define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    // data port (from EX/MEM register)
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    // external bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    // A zero limit would make the watchdog compare meaningless.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic                bus_err_q, bus_err_d;

    logic mem_pending;
    logic timeout_hit;   // BUSY cycle that reaches the watchdog limit with no ack

    assign mem_pending = mem_re | mem_we;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog: held at zero in IDLE, counts every BUSY cycle without ack.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == IDLE) begin
            wd_cnt_d = '0;
        end else if (!bus_ack) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Ack in the limit cycle wins, so the abort needs !bus_ack.
    assign timeout_hit = (state_q != IDLE) && !bus_ack &&
                         (wd_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_sel_q    <= '0;
            bus_wdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_sel_q    <= bus_sel_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Next state: grant in IDLE (tie goes to the port not served last), leave BUSY on ack or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_pending && (!if_req || last_grant_q == GRANT_IF)) begin
                    state_d = MEM_BUSY;
                end else if (if_req) begin
                    state_d = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (bus_ack || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: latch the bus cycle on grant, capture data and pulse ready on completion.
    always_comb begin
        last_grant_d = last_grant_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_sel_d    = bus_sel_q;
        bus_wdata_d  = bus_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        bus_err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (state_d == MEM_BUSY) begin
                // read+write together is a write; reads drive zero data
                bus_req_d   = 1'b1;
                bus_we_d    = mem_we;
                bus_addr_d  = mem_addr;
                bus_sel_d   = mem_sel;
                bus_wdata_d = mem_we ? mem_wdata : '0;
            end else if (state_d == IF_BUSY) begin
                bus_req_d   = 1'b1;
                bus_we_d    = 1'b0;
                bus_addr_d  = if_addr;
                bus_sel_d   = '1;
                bus_wdata_d = '0;
            end
        end else if (bus_ack || timeout_hit) begin
            bus_req_d    = 1'b0;
            bus_we_d     = 1'b0;
            bus_addr_d   = '0;
            bus_sel_d    = '0;
            bus_wdata_d  = '0;
            bus_err_d    = timeout_hit;
            last_grant_d = (state_q == MEM_BUSY) ? GRANT_MEM : GRANT_IF;
            if (state_q == IF_BUSY) begin
                if_ready_d = 1'b1;
                if_rdata_d = bus_ack ? bus_rdata : '0;
            end else begin
                mem_ready_d = 1'b1;
                // stores leave the load data register untouched
                if (!bus_we_q) begin
                    mem_rdata_d = bus_ack ? bus_rdata : '0;
                end
            end
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;

    // Stalls fall in the ready cycle so the pipeline advances exactly on ready.
    assign if_stall  = if_req & ~if_ready_q;
    assign mem_stall = mem_pending & ~mem_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: scoreboard queue of expected bus cycles,
// a bus responder with programmable wait states, and one task per scenario.
// Define ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT=4.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              mem_re = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [SEL_W-1:0]  mem_sel = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [SEL_W-1:0]  bus_sel;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata = '0;
    logic              bus_ack = 1'b0;
    logic              bus_err;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_sel  (mem_sel),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_stall(mem_stall),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_sel  (bus_sel),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_mem;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        bit                err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] if_model  = '0;   // expected if_rdata register contents
    logic [31:0] mem_model = '0;   // expected mem_rdata register contents
    bit          resp_en   = 1'b0;
    int          resp_wait = 0;

    // memory contents seen by the bus responder
    function automatic logic [31:0] rdata_fn(input logic [ADDR_W-1:0] a);
        if (a == 30'h10) return 32'h2402000A;
        return {a, 2'b00} ^ 32'hC0DE_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: acks after resp_wait cycles of bus_req.
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                rcnt = 0;
            end else if (!bus_req) begin
                bus_ack = 1'b0;
                rcnt = 0;
            end else begin
                if (rcnt == resp_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata_fn(bus_addr);
                end else begin
                    bus_ack = 1'b0;
                end
                rcnt++;
            end
        end
    end

    // Scoreboard monitor: grant fields, bus stability, completion data.
    initial begin
        logic                             prev_req;
        logic [ADDR_W+SEL_W+DATA_W:0]     held;
        exp_t                             g;
        prev_req = 1'b0;
        held = '0;
        forever begin
            @(posedge clk);
            #3;
            if (bus_req && !prev_req) begin
                checks++;
                held = {bus_we, bus_addr, bus_sel, bus_wdata};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected got addr=%h we=%0d required no grant", bus_addr, bus_we);
                end else begin
                    g = exp_q[0];
                    if (held !== {g.we, g.addr, g.sel, g.wdata}) begin
                        failures++;
                        $display("FAIL grant_fields got we=%0d addr=%h sel=%h wdata=%h required we=%0d addr=%h sel=%h wdata=%h",
                                 bus_we, bus_addr, bus_sel, bus_wdata, g.we, g.addr, g.sel, g.wdata);
                    end
                end
            end else if (bus_req) begin
                checks++;
                if ({bus_we, bus_addr, bus_sel, bus_wdata} !== held) begin
                    failures++;
                    $display("FAIL bus_stable got %h required %h", {bus_we, bus_addr, bus_sel, bus_wdata}, held);
                end
            end
            if (bus_req && exp_q.size() > 0) begin
                checks++;
                assert (exp_q[0].is_mem ? (mem_re | mem_we) : if_req) else begin
                    failures++;
                    $display("FAIL req_dropped_mid_transfer got req=0 required req=1 (port %s)", exp_q[0].is_mem ? "MEM" : "IF");
                end
            end
            if (if_ready || mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ready_unexpected got if_ready=%0d mem_ready=%0d required none", if_ready, mem_ready);
                end else begin
                    g = exp_q.pop_front();
                    if ({if_ready, mem_ready} !== (g.is_mem ? 2'b01 : 2'b10)) begin
                        failures++;
                        $display("FAIL ready_port got if_ready=%0d mem_ready=%0d required port %s",
                                 if_ready, mem_ready, g.is_mem ? "MEM" : "IF");
                    end
                    checks++;
                    if (bus_err !== g.err) begin
                        failures++;
                        $display("FAIL ready_err got %0d required %0d", bus_err, g.err);
                    end
                    if (g.is_mem && !g.we) mem_model = g.rdata;
                    if (!g.is_mem) if_model = g.rdata;
                    checks++;
                    if ({if_rdata, mem_rdata} !== {if_model, mem_model}) begin
                        failures++;
                        $display("FAIL ready_rdata got if=%h mem=%h required if=%h mem=%h",
                                 if_rdata, mem_rdata, if_model, mem_model);
                    end
                    $display("TXN port=%s we=%0d addr=%h sel=%h wdata=%h rdata=%h err=%0d",
                             g.is_mem ? "MEM" : "IF", g.we, g.addr, g.sel, g.wdata, g.rdata, g.err);
                end
            end else begin
                checks++;
                if (bus_err !== 1'b0) begin
                    failures++;
                    $display("FAIL bus_err_spurious got 1 required 0");
                end
            end
            prev_req = bus_req;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err, if_ready, mem_ready,
             if_rdata, mem_rdata, if_stall, mem_stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%0d addr=%h rdata=%h/%h required all 0",
                     bus_req, bus_addr, if_rdata, mem_rdata);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got bus_req=%0d required 0", bus_req);
        end
    endtask

    task automatic test_if_read();
        cyc();
        if_req = 1'b1;
        if_addr = 30'h10;
        exp_q.push_back('{1'b0, 1'b0, 30'h10, 4'hF, 32'h0, rdata_fn(30'h10), 1'b0});
        resp_wait = 0;
        resp_en = 1'b1;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin
            failures++;
            $display("FAIL if_stall_c0 got %0d required 1", if_stall);
        end
        cyc();
        checks++;
        if ({bus_req, if_stall, if_ready} !== 3'b110) begin
            failures++;
            $display("FAIL if_c1 got req/stall/ready=%b required 110", {bus_req, if_stall, if_ready});
        end
        cyc();
        checks++;
        if ({if_ready, if_stall, if_rdata} !== {1'b1, 1'b0, 32'h2402000A}) begin
            failures++;
            $display("FAIL if_c2 got ready=%0d stall=%0d rdata=%h required 1 0 2402000a", if_ready, if_stall, if_rdata);
        end
        if_req = 1'b0;
        cyc();
        checks++;
        if ({if_ready, bus_req} !== 2'b00) begin
            failures++;
            $display("FAIL if_c3 got ready=%0d req=%0d required 0 0", if_ready, bus_req);
        end
    endtask

    task automatic test_mem_read();
        int n;
        cyc();
        mem_re = 1'b1;
        mem_addr = 30'h33;
        mem_sel = 4'b1100;
        mem_wdata = 32'h1234_5678;
        exp_q.push_back('{1'b1, 1'b0, 30'h33, 4'b1100, 32'h0, rdata_fn(30'h33), 1'b0});
        resp_wait = 2;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_ready && n < 20);
        mem_re = 1'b0;
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL mem_read_latency got %0d required 4", n);
        end
    endtask

    task automatic test_mem_write();
        cyc();
        mem_we = 1'b1;
        mem_addr = 30'h20;
        mem_sel = 4'b0011;
        mem_wdata = 32'hDEADBEEF;
        exp_q.push_back('{1'b1, 1'b1, 30'h20, 4'b0011, 32'hDEADBEEF, 32'h0, 1'b0});
        resp_wait = 3;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL mem_write_stall_c0 got %0d required 1", mem_stall);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if ({bus_req, bus_we, mem_ready, mem_stall} !== 4'b1101) begin
                failures++;
                $display("FAIL mem_write_busy_c%0d got req/we/ready/stall=%b required 1101", k,
                         {bus_req, bus_we, mem_ready, mem_stall});
            end
        end
        cyc();
        checks++;
        if ({mem_ready, mem_stall, bus_req} !== 3'b100) begin
            failures++;
            $display("FAIL mem_write_ready_c5 got ready/stall/req=%b required 100", {mem_ready, mem_stall, bus_req});
        end
        mem_we = 1'b0;
        cyc();
        checks++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL mem_write_pulse got mem_ready=%0d required 0", mem_ready);
        end
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        bus_ack = 1'b0;
        cyc();
        mem_re = 1'b1;
        mem_addr = 30'h40;
        mem_sel = 4'hF;
        mem_wdata = '0;
        exp_q.push_back('{1'b1, 1'b0, 30'h40, 4'hF, 32'h0, rdata_fn(30'h40), 1'b0});
        cyc();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_grant got bus_req=%0d required 1", bus_req);
        end
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if ({bus_req, mem_ready, if_rdata, mem_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_mid_c4 got req=%0d ready=%0d rdata=%h/%h required all 0",
                     bus_req, mem_ready, if_rdata, mem_rdata);
        end
        rst = 1'b0;
        mem_re = 1'b0;
        exp_q.delete();
        if_model = '0;
        mem_model = '0;
        for (int k = 5; k <= 8; k++) begin
            cyc();
            checks++;
            if ({bus_req, mem_ready} !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_c%0d got req=%0d mem_ready=%0d required 0 0", k, bus_req, mem_ready);
            end
        end
        resp_en = 1'b1;
    endtask

    task automatic test_tie_fairness();
        int  done;
        int  n;
        bit  last_ready;
        cyc();
        if_req = 1'b1;
        if_addr = 30'h100;
        mem_re = 1'b1;
        mem_addr = 30'h200;
        mem_sel = 4'h5;
        mem_wdata = '0;
        resp_wait = 1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{1'b1, 1'b0, 30'h200, 4'h5, 32'h0, rdata_fn(30'h200), 1'b0});
            exp_q.push_back('{1'b0, 1'b0, 30'h100, 4'hF, 32'h0, rdata_fn(30'h100), 1'b0});
        end
        done = 0;
        n = 0;
        last_ready = 1'b0;
        while (done < 4 && n < 40) begin
            cyc();
            n++;
            if (last_ready) begin
                checks++;
                if (bus_req !== 1'b1) begin
                    failures++;
                    $display("FAIL tie_regrant got bus_req=%0d required 1", bus_req);
                end
            end
            last_ready = if_ready | mem_ready;
            if (last_ready) begin
                done++;
                checks++;
                if (bus_req !== 1'b0) begin
                    failures++;
                    $display("FAIL tie_ready_idle got bus_req=%0d required 0", bus_req);
                end
            end
        end
        if_req = 1'b0;
        mem_re = 1'b0;
        checks++;
        if (done !== 4) begin
            failures++;
            $display("FAIL tie_count got %0d completions required 4", done);
        end
        cyc();
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL tie_quiet got bus_req=%0d required 0", bus_req);
        end
    endtask

    task automatic test_rw_both();
        int n;
        cyc();
        mem_re = 1'b1;
        mem_we = 1'b1;
        mem_addr = 30'h77;
        mem_sel = 4'b1001;
        mem_wdata = 32'hCAFEF00D;
        exp_q.push_back('{1'b1, 1'b1, 30'h77, 4'b1001, 32'hCAFEF00D, 32'h0, 1'b0});
        resp_wait = 0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_ready && n < 20);
        mem_re = 1'b0;
        mem_we = 1'b0;
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL rw_both_latency got %0d required 2", n);
        end
    endtask

    task automatic test_idle_ack();
        resp_en = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        bus_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({bus_req, if_ready, mem_ready, if_rdata, mem_rdata} !== {3'b000, if_model, mem_model}) begin
                failures++;
                $display("FAIL idle_ack got req=%0d ready=%0d/%0d rdata=%h/%h required 0 0/0 %h/%h",
                         bus_req, if_ready, mem_ready, if_rdata, mem_rdata, if_model, mem_model);
            end
        end
        bus_ack = 1'b0;
        resp_en = 1'b1;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        resp_en = 1'b0;
        bus_ack = 1'b0;
        cyc();
        mem_re = 1'b1;
        mem_addr = 30'h50;
        mem_sel = 4'hF;
        exp_q.push_back('{1'b1, 1'b0, 30'h50, 4'hF, 32'h0, 32'h0, 1'b1});
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if ({bus_req, bus_err, mem_ready} !== 3'b100) begin
                failures++;
                $display("FAIL timeout_wait_c%0d got req/err/ready=%b required 100", k, {bus_req, bus_err, mem_ready});
            end
        end
        cyc();
        checks++;
        if ({bus_err, mem_ready, bus_req, mem_rdata} !== {3'b110, 32'h0}) begin
            failures++;
            $display("FAIL timeout_abort got err=%0d ready=%0d req=%0d rdata=%h required 1 1 0 0",
                     bus_err, mem_ready, bus_req, mem_rdata);
        end
        mem_re = 1'b0;
        cyc();
        checks++;
        if ({bus_err, mem_ready} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_pulse got err=%0d ready=%0d required 0 0", bus_err, mem_ready);
        end
        // ack arriving in the limit cycle completes normally
        mem_re = 1'b1;
        mem_addr = 30'h51;
        exp_q.push_back('{1'b1, 1'b0, 30'h51, 4'hF, 32'h0, rdata_fn(30'h51), 1'b0});
        repeat (4) cyc();
        bus_ack = 1'b1;
        bus_rdata = rdata_fn(30'h51);
        cyc();
        checks++;
        if ({mem_ready, bus_err, mem_rdata} !== {2'b10, rdata_fn(30'h51)}) begin
            failures++;
            $display("FAIL timeout_ack_wins got ready=%0d err=%0d rdata=%h required 1 0 %h",
                     mem_ready, bus_err, mem_rdata, rdata_fn(30'h51));
        end
        bus_ack = 1'b0;
        mem_re = 1'b0;
        cyc();
        resp_en = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        int n;
        cyc();
        mem_re = 1'b1;
        mem_addr = 30'h60;
        mem_sel = 4'hF;
        exp_q.push_back('{1'b1, 1'b0, 30'h60, 4'hF, 32'h0, rdata_fn(30'h60), 1'b0});
        resp_wait = 300;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_ready && n < 400);
        mem_re = 1'b0;
        checks++;
        if (n !== 302) begin
            failures++;
            $display("FAIL long_wait_latency got %0d required 302", n);
        end
        resp_wait = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_if_read();
        test_mem_read();
        test_mem_write();
        test_reset_mid();
        test_tie_fairness();
        test_rw_both();
        test_idle_ack();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) cyc();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch (IF) port and the data (MEM stage) port.
- MEM requests come from the EX/MEM pipeline register's read/write enables, word address and byte selects.
- Arbitrates between the two ports with a last-grant tie-break, holds bus signals stable until acknowledge, and returns read data with a one-cycle ready pulse.
- Generates the per-port stall signals consumed by the pipeline stall logic.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- DATA_W, 32, data word width.
- SEL_W, 4, byte-select width (DATA_W/8).
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched word; registered, valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req & ~if_ready (combinational).
- mem_re  in  1  data read request.
- mem_we  in  1  data write request; mem_re=mem_we=1 is treated as a write.
- mem_addr  in  ADDR_W  data word address.
- mem_sel  in  SEL_W  byte enables.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; registered, valid when mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- mem_stall  out  1  (mem_re|mem_we) & ~mem_ready (combinational).
- bus_req  out  1  bus cycle active.
- bus_we  out  1  1=write, 0=read.
- bus_addr  out  ADDR_W  bus word address.
- bus_sel  out  SEL_W  bus byte enables; 4'b1111 for IF.
- bus_wdata  out  DATA_W  bus write data; 0 for reads.
- bus_rdata  in  DATA_W  bus read data, sampled with bus_ack.
- bus_ack  in  1  bus completion, may be asserted in the first cycle bus_req=1.
- bus_err  out  1  timeout abort pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: every output 0, state IDLE, last_grant=IF, watchdog counter 0. rst mid-transaction abandons the transfer. bus_req is 0 the next cycle and no ready pulse is issued.
- States and transitions:
  - IDLE:
    - Only MEM pending goes to MEM_BUSY.
    - Only if_req goes to IF_BUSY.
    - Both pending: grant the port that was not last_grant. Since last_grant resets to IF, MEM wins the first tie.
    - Entering a BUSY state latches addr/sel/wdata/we onto the bus_* registers and sets bus_req=1. These values are frozen until ack.
  - IF_BUSY / MEM_BUSY:
    - Wait for bus_ack.
    - On ack: register bus_rdata into if_rdata or mem_rdata, pulse the matching ready for 1 cycle, update last_grant, clear bus_req and bus_we/addr/sel/wdata to 0, return to IDLE.
    - For MEM writes, mem_rdata is held unchanged.
- Latency: request seen in IDLE at cycle 0 gives bus_req=1 at cycle 1. bus_ack at cycle n gives ready=1 at cycle n+1. Zero-wait memory therefore completes in 2 cycles.
- Back-to-back: the cycle with ready=1 is spent in IDLE and arbitrates new requests, so a port has at most 1 bubble between transfers.
- Requester deasserting req mid-transfer: the transfer still completes and ready still pulses. The protocol forbids this; a bench assertion flags it.
- bus_ack while in IDLE is ignored.
- rdata registers keep their last value between transfers.
- Stalls drop in the same cycle ready pulses, so the pipeline advances exactly on ready.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With it defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the transfer aborts: bus_err pulses 1 cycle, the owning port's ready pulses with rdata=0, bus_req drops, state returns to IDLE, and last_grant updates.
  - Ack in the same cycle as the limit takes priority: normal completion, no error.
- Without it: no counter, bus_err constant 0, wait indefinitely.

Test Plan:
- Reset mid-transfer: MEM read granted, bus_ack held 0, rst at cycle 3 -> cycle 4 bus_req=0, mem_ready never pulses, last_grant=IF.
- IF read, zero-wait: if_req, if_addr=0x0000010, bus_ack=1 with bus_rdata=0x2402000A in first bus_req cycle -> bus_addr=0x0000010, bus_sel=1111, bus_we=0; if_ready=1 at cycle 2, if_rdata=0x2402000A, if_stall=1 for cycles 0-1.
- MEM write with wait states: mem_we, addr 0x0000020, sel 0011, wdata 0xDEADBEEF, ack after 3 wait cycles -> bus signals stable 4 cycles, bus_we=1, mem_ready at cycle 5, mem_rdata unchanged.
- Tie, then fairness: if_req and mem_re both asserted continuously -> grants MEM, IF, MEM, IF; each ready precedes the next bus_req by one IDLE cycle.
- ARB_TIMEOUT_EN with TIMEOUT=4: MEM read, no ack -> bus_err and mem_ready pulse together 4 cycles after bus_req rose, mem_rdata=0; ack arriving in the limit cycle -> normal completion, bus_err=0.
